// File: rtl/fadd_arb_pkg.sv
// fadd_arb_pkg: shared defaults, float sign position, clog2 helper and requester tag type for the float-adder arbiter
package fadd_arb_pkg;
  localparam int DW_DEFAULT = 32;
  localparam int FP_SIGN_BIT = DW_DEFAULT - 1;
  localparam int N_REQ_DEFAULT = 4;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  typedef logic [clog2(N_REQ_DEFAULT)-1:0] tag_t;
endpackage

// File: rtl/fadd_share_arb_if.sv
// fadd_share_arb_if: requester, result and adder-side AXI-stream bundle (slave = arbiter side); req_sub exists only with FADD_ARB_SUB_EN
interface fadd_share_arb_if import fadd_arb_pkg::*; #(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int DW = DW_DEFAULT
);
  logic [N_REQ-1:0] req_tvalid;
  logic [N_REQ-1:0] req_tready;
  logic [N_REQ*DW-1:0] req_a_tdata;
  logic [N_REQ*DW-1:0] req_b_tdata;
`ifdef FADD_ARB_SUB_EN
  logic [N_REQ-1:0] req_sub;
`endif
  logic [N_REQ-1:0] res_tvalid;
  logic [N_REQ-1:0] res_tready;
  logic [DW-1:0] res_tdata;
  logic add_a_tvalid;
  logic add_a_tready;
  logic [DW-1:0] add_a_tdata;
  logic add_b_tvalid;
  logic add_b_tready;
  logic [DW-1:0] add_b_tdata;
  logic add_res_tvalid;
  logic add_res_tready;
  logic [DW-1:0] add_res_tdata;
  modport slave (
`ifdef FADD_ARB_SUB_EN
    input req_sub,
`endif
    input req_tvalid, req_a_tdata, req_b_tdata, res_tready,
    input add_a_tready, add_b_tready, add_res_tvalid, add_res_tdata,
    output req_tready, res_tvalid, res_tdata,
    output add_a_tvalid, add_a_tdata, add_b_tvalid, add_b_tdata, add_res_tready
  );
  modport master (
`ifdef FADD_ARB_SUB_EN
    output req_sub,
`endif
    output req_tvalid, req_a_tdata, req_b_tdata, res_tready,
    output add_a_tready, add_b_tready, add_res_tvalid, add_res_tdata,
    input req_tready, res_tvalid, res_tdata,
    input add_a_tvalid, add_a_tdata, add_b_tvalid, add_b_tdata, add_res_tready
  );
endinterface

// File: rtl/fadd_arb_tag_fifo.sv
// fadd_arb_tag_fifo: synchronous in-order tag FIFO (push/pop, head, count/full/empty), async active-low reset
module fadd_arb_tag_fifo import fadd_arb_pkg::*; #(
  parameter int W = $bits(tag_t),
  parameter int DEPTH = 16
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic push,
  input  logic [W-1:0] push_data,
  input  logic pop,
  output logic [W-1:0] head,
  output logic [clog2(DEPTH):0] count,
  output logic full,
  output logic empty
);
  localparam int AW = clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = (push == pop) ? cnt_q : push ? cnt_q + (AW+1)'(1) : cnt_q - (AW+1)'(1);
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge aclk)
    if (push) mem_q[wr_q] <= push_data;
  assign head = mem_q[rd_q];
  assign count = cnt_q;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/fadd_share_arb.sv
// fadd_share_arb: round-robin time-sharing of one AXI-stream float adder among N_REQ requesters with in-order result routing; FADD_ARB_SUB_EN adds per-lane subtract
module fadd_share_arb import fadd_arb_pkg::*; #(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int MAX_INFLIGHT = 16,
  parameter int DW = DW_DEFAULT
) (
  input  logic aclk,
  input  logic aresetn,
  fadd_share_arb_if.slave bus,
  output logic [clog2(MAX_INFLIGHT):0] inflight,
  output logic tag_err
);
  localparam int TW = clog2(N_REQ);
  logic [TW-1:0] rr_q, rr_d, grant, idx, head;
  logic a_pend_q, a_pend_d, b_pend_q, b_pend_d, tag_err_q, tag_err_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d, b_in;
  logic found, load, full, empty, pop;
  always_comb begin
    grant = rr_q;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = TW'((int'(rr_q) + k) % N_REQ);
      if (!found && bus.req_tvalid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end
  assign load = aresetn && found && !a_pend_q && !b_pend_q && !full;
`ifdef FADD_ARB_SUB_EN
  assign b_in = bus.req_b_tdata[int'(grant)*DW +: DW] ^ {bus.req_sub[grant], {(DW-1){1'b0}}};
`else
  assign b_in = bus.req_b_tdata[int'(grant)*DW +: DW];
`endif
  always_comb begin
    rr_d = load ? ((grant == TW'(N_REQ-1)) ? '0 : grant + TW'(1)) : rr_q;
    a_pend_d = load | (a_pend_q & ~bus.add_a_tready);
    b_pend_d = load | (b_pend_q & ~bus.add_b_tready);
    a_d = load ? bus.req_a_tdata[int'(grant)*DW +: DW] : a_q;
    b_d = load ? b_in : b_q;
    tag_err_d = tag_err_q | (bus.add_res_tvalid & empty);
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      rr_q <= '0;
      a_pend_q <= 1'b0;
      b_pend_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      tag_err_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
      a_pend_q <= a_pend_d;
      b_pend_q <= b_pend_d;
      a_q <= a_d;
      b_q <= b_d;
      tag_err_q <= tag_err_d;
    end
  fadd_arb_tag_fifo #(.W(TW), .DEPTH(MAX_INFLIGHT)) u_tag_fifo (
    .aclk(aclk),
    .aresetn(aresetn),
    .push(load),
    .push_data(grant),
    .pop(pop),
    .head(head),
    .count(inflight),
    .full(full),
    .empty(empty)
  );
  assign pop = bus.add_res_tvalid & bus.add_res_tready;
  assign bus.req_tready = load ? N_REQ'(1) << grant : '0;
  assign bus.add_a_tvalid = a_pend_q;
  assign bus.add_a_tdata = a_q;
  assign bus.add_b_tvalid = b_pend_q;
  assign bus.add_b_tdata = b_q;
  assign bus.add_res_tready = !empty && bus.res_tready[head];
  assign bus.res_tvalid = (bus.add_res_tvalid && !empty) ? N_REQ'(1) << head : '0;
  assign bus.res_tdata = bus.add_res_tdata;
  assign tag_err = tag_err_q;
endmodule

// File: tb/tb_fadd_share_arb.sv
// tb_fadd_share_arb: directed vectors and corner sequences for fadd_share_arb against a latency-8 stub adder
module tb_fadd_share_arb;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;
  fadd_share_arb_if #(.N_REQ(4), .DW(32)) bus ();
  logic [4:0] inflight;
  logic tag_err;
  fadd_share_arb #(.N_REQ(4), .MAX_INFLIGHT(16), .DW(32)) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .bus(bus),
    .inflight(inflight),
    .tag_err(tag_err)
  );
  int checks = 0;
  int errors = 0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  function automatic logic [63:0] sp2dp(input logic [31:0] x);
    return (x[30:0] == 0) ? {x[31], 63'b0} : {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'b0};
  endfunction
  function automatic logic [31:0] dp2sp(input logic [63:0] d);
    logic [10:0] e;
    e = d[62:52] - 11'd896;
    return (d[62:0] == 0) ? {d[63], 31'b0} : {d[63], e[7:0], d[51:29]};
  endfunction
  function automatic logic [31:0] fpadd(input logic [31:0] a, input logic [31:0] b);
    real r;
    r = $bitstoreal(sp2dp(a)) + $bitstoreal(sp2dp(b));
    return dp2sp($realtobits(r));
  endfunction
  function automatic logic [3:0] oh(input int l);
    return 4'b0001 << l;
  endfunction
  logic a_rdy = 1'b1, b_rdy = 1'b1, inject = 1'b0;
  logic stub_v = 1'b0;
  logic [31:0] stub_d = '0;
  assign bus.add_a_tready = a_rdy;
  assign bus.add_b_tready = b_rdy;
  assign bus.add_res_tvalid = aresetn & (stub_v | inject);
  assign bus.add_res_tdata = inject ? 32'h12345678 : stub_d;
  typedef struct { logic [31:0] val; int due; } rq_t;
  typedef struct { int lane; logic [31:0] val; } sb_t;
  rq_t res_q[$];
  sb_t exp_q[$];
  int acc_lane[$];
  int acc_cyc[$];
  int cyc = 0;
  int a_hs_cnt = 0;
  logic hs_a = 0, hs_b = 0, hs_r = 0, got_a = 0, got_b = 0;
  logic [31:0] cap_a, cap_b, sa, sbv;
  always begin
    @(negedge aclk);
    cyc++;
    if (!aresetn) begin
      res_q.delete();
      exp_q.delete();
      acc_lane.delete();
      acc_cyc.delete();
      got_a = 0;
      got_b = 0;
      hs_a = 0;
      hs_b = 0;
      hs_r = 0;
    end else begin
      if (hs_r && res_q.size() > 0) void'(res_q.pop_front());
      if (hs_a) begin got_a = 1; sa = cap_a; end
      if (hs_b) begin got_b = 1; sbv = cap_b; end
      if (got_a && got_b) begin
        res_q.push_back('{fpadd(sa, sbv), cyc + 8});
        got_a = 0;
        got_b = 0;
      end
    end
    stub_v = 0;
    stub_d = '0;
    if (res_q.size() > 0) begin
      stub_v = res_q[0].due <= cyc;
      stub_d = res_q[0].val;
    end
    #3;
    hs_a = bus.add_a_tvalid & bus.add_a_tready;
    hs_b = bus.add_b_tvalid & bus.add_b_tready;
    cap_a = bus.add_a_tdata;
    cap_b = bus.add_b_tdata;
    hs_r = bus.add_res_tvalid & bus.add_res_tready;
    if (hs_a) a_hs_cnt++;
    if (bus.req_tready != 0) begin
      int l;
      logic [31:0] b;
      l = 0;
      for (int i = 0; i < 4; i++) if (bus.req_tready[i]) l = i;
      b = bus.req_b_tdata[l*32 +: 32];
`ifdef FADD_ARB_SUB_EN
      b[31] = b[31] ^ bus.req_sub[l];
`endif
      exp_q.push_back('{l, fpadd(bus.req_a_tdata[l*32 +: 32], b)});
      acc_lane.push_back(l);
      acc_cyc.push_back(cyc);
    end
    if ((bus.res_tvalid & bus.res_tready) != 0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: result on lanes %b with nothing expected", bus.res_tvalid);
      end else begin
        sb_t e;
        e = exp_q.pop_front();
        chk("sb_lane", bus.res_tvalid & bus.res_tready, oh(e.lane));
        chk("sb_data", bus.res_tdata, e.val);
      end
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge aclk);
      #2;
    end
  endtask
  task automatic do_reset();
    aresetn = 1'b0;
    bus.req_tvalid = '0;
    inject = 0;
    a_rdy = 1;
    b_rdy = 1;
    bus.res_tready = '1;
    tick(2);
    aresetn = 1'b1;
    tick(1);
  endtask
  task automatic set_lanes();
    for (int i = 0; i < 4; i++) begin
      bus.req_a_tdata[i*32 +: 32] = 32'h3F800000 + (i == 0 ? 32'h0 : i == 1 ? 32'h00800000 : i == 2 ? 32'h00C00000 : 32'h01000000);
      bus.req_b_tdata[i*32 +: 32] = 32'h3F800000;
    end
  endtask
  task automatic drain(input string n);
    for (int t = 0; t < 120 && (exp_q.size() != 0 || inflight != 0); t++) tick;
    chk(n, 64'(exp_q.size() == 0 && inflight == 0), 1);
  endtask
  typedef struct { int lane; logic [31:0] a, b; logic sub; logic [31:0] exp_b, exp_res; } vec_t;
  vec_t vt [5];
  initial begin
    bit got;
    int a0;
    vt[0] = '{0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40000000, 32'h40400000};
    vt[1] = '{1, 32'h40400000, 32'h3F800000, 1'b0, 32'h3F800000, 32'h40800000};
    vt[2] = '{3, 32'h3F000000, 32'h3F000000, 1'b0, 32'h3F000000, 32'h3F800000};
`ifdef FADD_ARB_SUB_EN
    vt[3] = '{2, 32'h3F800000, 32'h40000000, 1'b1, 32'hC0000000, 32'hBF800000};
`else
    vt[3] = '{2, 32'h3F800000, 32'h40000000, 1'b1, 32'h40000000, 32'h40400000};
`endif
    vt[4] = '{1, 32'h40A00000, 32'hC0400000, 1'b0, 32'hC0400000, 32'h40000000};
    bus.req_a_tdata = '0;
    bus.req_b_tdata = '0;
`ifdef FADD_ARB_SUB_EN
    bus.req_sub = '0;
`endif
    bus.res_tready = '1;
    bus.req_tvalid = '1;
    tick(2);
    chk("rst_req_tready", bus.req_tready, 0);
    chk("rst_a_tvalid", bus.add_a_tvalid, 0);
    chk("rst_b_tvalid", bus.add_b_tvalid, 0);
    chk("rst_res_tvalid", bus.res_tvalid, 0);
    chk("rst_add_res_tready", bus.add_res_tready, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_tag_err", tag_err, 0);
    bus.req_tvalid = '0;
    aresetn = 1'b1;
    tick;
    for (int v = 0; v < 5; v++) begin
      bus.req_a_tdata[vt[v].lane*32 +: 32] = vt[v].a;
      bus.req_b_tdata[vt[v].lane*32 +: 32] = vt[v].b;
`ifdef FADD_ARB_SUB_EN
      bus.req_sub = 4'(vt[v].sub) << vt[v].lane;
`endif
      bus.req_tvalid = oh(vt[v].lane);
      #1;
      chk("v_req_tready", bus.req_tready, oh(vt[v].lane));
      tick;
      bus.req_tvalid = '0;
      chk("v_a_tvalid", bus.add_a_tvalid, 1);
      chk("v_b_tvalid", bus.add_b_tvalid, 1);
      chk("v_a_tdata", bus.add_a_tdata, vt[v].a);
      chk("v_b_tdata", bus.add_b_tdata, vt[v].exp_b);
      chk("v_inflight1", inflight, 1);
      got = 0;
      for (int t = 0; t < 40 && !got; t++) begin
        tick;
        got = bus.res_tvalid != 0;
      end
      chk("v_res_tvalid", bus.res_tvalid, oh(vt[v].lane));
      chk("v_res_tdata", bus.res_tdata, vt[v].exp_res);
      tick;
      chk("v_inflight0", inflight, 0);
    end
`ifdef FADD_ARB_SUB_EN
    bus.req_sub = '0;
`endif
    do_reset();
    set_lanes();
    bus.req_tvalid = '1;
    for (int t = 0; t < 40 && acc_lane.size() < 8; t++) tick;
    bus.req_tvalid = '0;
    chk("rr_count", 64'(acc_lane.size()), 8);
    for (int i = 0; i < 8 && i < acc_lane.size(); i++) chk("rr_lane", 64'(acc_lane[i]), 64'(i % 4));
    for (int i = 1; i < 8 && i < acc_cyc.size(); i++) chk("rr_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 2);
    drain("rr_drain");
    do_reset();
    a_rdy = 1;
    b_rdy = 0;
    bus.req_a_tdata[31:0] = 32'h3F800000;
    bus.req_b_tdata[31:0] = 32'h40000000;
    bus.req_a_tdata[63:32] = 32'h40400000;
    bus.req_b_tdata[63:32] = 32'h3F800000;
    bus.req_tvalid = 4'b0011;
    a0 = a_hs_cnt;
    tick;
    chk("split_a_tvalid1", bus.add_a_tvalid, 1);
    chk("split_req_tready1", bus.req_tready, 0);
    bus.req_tvalid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("split_a_tvalid0", bus.add_a_tvalid, 0);
      chk("split_b_tvalid", bus.add_b_tvalid, 1);
      chk("split_b_tdata", bus.add_b_tdata, 32'h40000000);
      chk("split_req_tready0", bus.req_tready, 0);
    end
    chk("split_a_once", 64'(a_hs_cnt - a0), 1);
    b_rdy = 1;
    tick;
    chk("split_b_done", bus.add_b_tvalid, 0);
    chk("split_next_grant", bus.req_tready, 4'b0010);
    tick;
    bus.req_tvalid = '0;
    drain("split_drain");
    do_reset();
    set_lanes();
    bus.res_tready = '0;
    bus.req_tvalid = '1;
    tick(45);
    chk("full_accepts", 64'(acc_lane.size()), 16);
    chk("full_inflight", inflight, 16);
    chk("full_req_tready", bus.req_tready, 0);
    bus.res_tready = '1;
    tick;
    bus.res_tready = '0;
    #1;
    chk("release_inflight", inflight, 15);
    chk("release_grant", bus.req_tready, 4'b0001);
    tick;
    bus.req_tvalid = '0;
    chk("refill_inflight", inflight, 16);
    bus.res_tready = '1;
    drain("full_drain");
    do_reset();
    set_lanes();
    bus.res_tready = '0;
    bus.req_tvalid = '1;
    for (int t = 0; t < 40 && acc_lane.size() < 5; t++) tick;
    a_rdy = 0;
    tick;
    chk("mid_inflight", inflight, 5);
    chk("mid_a_pend", bus.add_a_tvalid, 1);
    aresetn = 1'b0;
    #1;
    chk("async_req_tready", bus.req_tready, 0);
    chk("async_a_tvalid", bus.add_a_tvalid, 0);
    chk("async_b_tvalid", bus.add_b_tvalid, 0);
    chk("async_res_tvalid", bus.res_tvalid, 0);
    chk("async_add_res_tready", bus.add_res_tready, 0);
    chk("async_inflight", inflight, 0);
    tick(2);
    aresetn = 1'b1;
    a_rdy = 1;
    #1;
    chk("post_rst_grant", bus.req_tready, 4'b0001);
    tick;
    bus.req_tvalid = '0;
    bus.res_tready = '1;
    drain("post_rst_drain");
    do_reset();
    chk("tagerr_clear", tag_err, 0);
    inject = 1;
    #1;
    chk("tagerr_add_res_tready", bus.add_res_tready, 0);
    chk("tagerr_res_tvalid", bus.res_tvalid, 0);
    tick;
    inject = 0;
    chk("tagerr_set", tag_err, 1);
    tick(3);
    chk("tagerr_sticky", tag_err, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
